// File: rtl/key_pkg.sv
// Shared debounce FSM encodings and default timing constants for the key front end.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } key_state_e;

    // 10 ms at 50 MHz
    localparam int KEY_CNT_MAX = 500000;
    localparam int KEY_CNT_W   = 19;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, press/release FSM with stability
// counter, and registered level/pulse outputs.
//
// state        | meaning
// IDLE         | key confirmed released, waiting for a pressed sample
// PRESS_WAIT   | pressed samples seen, counting toward confirmation
// PRESSED      | key confirmed pressed (key_level=1)
// RELEASE_WAIT | released samples seen, counting toward confirmation
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int CNT_MAX        = KEY_CNT_MAX,
    parameter int CNT_W          = KEY_CNT_W,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_pulse,
    output logic key_release
);

    localparam logic             IDLE_LVL = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [1:0]       sync_q;
    logic             sample;
    key_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pulse_nxt, release_nxt, level_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {2{IDLE_LVL}};
        else     sync_q <= {sync_q[0], key_raw};
    end

    assign sample = KEY_ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_pulse   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_level   <= level_nxt;
            key_pulse   <= pulse_nxt;
            key_release <= release_nxt;
        end
    end

    // Counter is cleared on every state change, so it can never pass CNT_LAST.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pulse_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (sample) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sample) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!sample) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sample) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
    end

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: one independent channel per key, bit order
// {load, pause, Record, start}.
module key_debounce
    import key_pkg::*;
#(
    parameter int NUM_KEYS       = 4,
    parameter int CNT_MAX        = KEY_CNT_MAX,
    parameter int CNT_W          = KEY_CNT_W,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic [NUM_KEYS-1:0] key_release
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .CNT_MAX        (CNT_MAX),
            .CNT_W          (CNT_W),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .key_raw     (key_in[i]),
            .key_level   (key_level[i]),
            .key_pulse   (key_pulse[i]),
            .key_release (key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with CNT_MAX=8: stimulus queues expected
// pulse/release events, a negedge monitor matches them against the outputs.
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in;
    logic [3:0] key_level, key_pulse, key_release;

    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    typedef struct {
        int unsigned at;
        logic [3:0]  pulse;
        logic [3:0]  rel;
    } exp_t;
    exp_t q[$];

    key_debounce #(
        .NUM_KEYS       (4),
        .CNT_MAX        (8),
        .CNT_W          (4),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_pulse   (key_pulse),
        .key_release (key_release)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // press first sampled at edge cyc+1 -> output visible after edge cyc+11
    localparam int unsigned LAT = 11;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [3:0] p, input logic [3:0] r);
        exp_t e;
        e.at = cyc + LAT;
        e.pulse = p;
        e.rel = r;
        q.push_back(e);
    endtask

    task automatic check_level(input string name, input logic [3:0] exp);
        n_vec++;
        if (key_level !== exp) begin
            n_bad++;
            $display("FAIL %s: key_level got %b want %b at cycle %0d", name, key_level, exp, cyc);
        end
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if ({key_level, key_pulse, key_release} !== 12'h000) begin
            n_bad++;
            $display("FAIL %s: level/pulse/release got %b/%b/%b want all zero",
                     name, key_level, key_pulse, key_release);
        end
    endtask

    // Monitor: expired expectations are misses, any active output must match the head.
    always @(negedge clk) begin
        while (q.size() != 0 && q[0].at < cyc) begin
            n_vec++;
            n_bad++;
            $display("FAIL missed_event: no output at cycle %0d, want pulse %b release %b",
                     q[0].at, q[0].pulse, q[0].rel);
            void'(q.pop_front());
        end
        if ((key_pulse | key_release) != 4'b0000) begin
            n_vec++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: pulse %b release %b at cycle %0d, want none",
                         key_pulse, key_release, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.at != cyc || e.pulse !== key_pulse || e.rel !== key_release) begin
                    n_bad++;
                    $display("FAIL event: got pulse %b release %b at cycle %0d, want pulse %b release %b at cycle %0d",
                             key_pulse, key_release, cyc, e.pulse, e.rel, e.at);
                end
            end
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        key_in = 4'hF;
        step(3);
        check_zero("reset_state");
        rst = 1'b0;
        step(5);
        check_zero("post_reset_idle");

        // clean press / release on key 0
        key_in[0] = 1'b0;
        expect_ev(4'b0001, 4'b0000);
        step(20);
        check_level("clean_level", 4'b0001);
        key_in[0] = 1'b1;
        expect_ev(4'b0000, 4'b0001);
        step(20);
        check_level("clean_release_level", 4'b0000);

        // bounce on key 1: low 3, 2, 5 with short high gaps, then held
        key_in[1] = 1'b0; step(3);
        key_in[1] = 1'b1; step(2);
        key_in[1] = 1'b0; step(2);
        key_in[1] = 1'b1; step(2);
        key_in[1] = 1'b0; step(5);
        key_in[1] = 1'b1; step(2);
        key_in[1] = 1'b0;
        expect_ev(4'b0010, 4'b0000);
        step(20);
        check_level("bounce_level", 4'b0010);
        key_in[1] = 1'b1;
        expect_ev(4'b0000, 4'b0010);
        step(20);

        // release glitch on key 2
        key_in[2] = 1'b0;
        expect_ev(4'b0100, 4'b0000);
        step(20);
        key_in[2] = 1'b1; step(4);
        key_in[2] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check_level("glitch_level", 4'b0100);
            step(1);
        end
        key_in[2] = 1'b1;
        expect_ev(4'b0000, 4'b0100);
        step(20);
        check_level("glitch_release_level", 4'b0000);

        // simultaneous press and release
        key_in = 4'b0000;
        expect_ev(4'b1111, 4'b0000);
        step(20);
        check_level("simul_level", 4'b1111);
        key_in = 4'b1111;
        expect_ev(4'b0000, 4'b1111);
        step(20);

        // reset at counter=5 in PRESS_WAIT, key held through deassertion
        key_in[0] = 1'b0;
        step(8);
        rst = 1'b1;
        #1;
        check_zero("reset_abort_immediate");
        step(3);
        check_zero("reset_abort_held");
        rst = 1'b0;
        expect_ev(4'b0001, 4'b0000);
        step(20);
        check_level("reset_repress_level", 4'b0001);
        key_in[0] = 1'b1;
        expect_ev(4'b0000, 4'b0001);
        step(20);

        // long hold on key 3
        key_in[3] = 1'b0;
        expect_ev(4'b1000, 4'b0000);
        step(12);
        for (int i = 0; i < 990; i++) begin
            check_level("long_hold_level", 4'b1000);
            step(1);
        end
        key_in[3] = 1'b1;
        expect_ev(4'b0000, 4'b1000);
        step(20);

        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: %0d left in scoreboard, want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- NUM_KEYS, 4, number of independent key channels; bit order {load, pause, Record, start}.
- CNT_MAX, 500000, stable cycles needed to confirm a level change (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 19, debounce counter width.
- KEY_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single system clock.
- rst, in, 1, asynchronous active-high reset.
- key_in, in, NUM_KEYS, raw, asynchronous, bouncing button inputs.
- key_level, out, NUM_KEYS, debounced level; 1 = pressed.
- key_pulse, out, NUM_KEYS, one-clk pulse on each confirmed press; drives the key_start, key_Record, key_pause and key_load edge inputs of the control stage.
- key_release, out, NUM_KEYS, one-clk pulse on each confirmed release.

REQ-003 The block SHALL use one clock (clk) and reset SHALL be asynchronous and active-high (rst). No other clock or reset SHALL exist.

Function
REQ-004 Each key_in bit SHALL pass through a 2-flop synchronizer and then be normalized to active-high (inverted when KEY_ACTIVE_LOW=1).
REQ-005 Each channel SHALL run an independent FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a CNT_W-bit counter.
REQ-006 IDLE: a normalized sample of 1 SHALL move the FSM to PRESS_WAIT with counter=0. A sample of 0 SHALL leave it in IDLE.
REQ-007 PRESS_WAIT: a sample of 1 SHALL increment the counter. When the counter equals CNT_MAX-1 and the sample is 1, the FSM SHALL go to PRESSED. A sample of 0 SHALL return it to IDLE with counter=0 and no pulse.
REQ-008 Entering PRESSED SHALL set key_level=1 and assert key_pulse for exactly one clk.
REQ-009 PRESSED: a sample of 0 SHALL move the FSM to RELEASE_WAIT with counter=0. A sample of 1 SHALL hold it in PRESSED.
REQ-010 RELEASE_WAIT: a sample of 0 SHALL increment the counter. At CNT_MAX-1 the FSM SHALL go to IDLE, clear key_level and pulse key_release for one clk. A sample of 1 SHALL return it to PRESSED with no new key_pulse.
REQ-011 Latency: a clean press first sampled at edge N SHALL produce key_pulse=1 during cycle N+2+CNT_MAX. Release latency SHALL be identical.
REQ-012 The counter SHALL never wrap. It is cleared on every state change and cannot exceed CNT_MAX-1.
REQ-013 Channels SHALL be fully independent. Simultaneous presses on several keys SHALL yield simultaneous pulses in the same cycle.
REQ-014 A key held indefinitely SHALL produce exactly one key_pulse, with no auto-repeat.
REQ-015 All outputs SHALL be registered, with no combinational path from key_in to any output.

Reset
REQ-016 While rst=1:
- All synchronizer flops SHALL hold the inactive level.
- All FSMs SHALL be in IDLE with counters at 0.
- key_level, key_pulse and key_release SHALL all be 0.
REQ-017 Reset asserted mid-debounce or mid-press SHALL abort the operation immediately, with no pulse emitted.
REQ-018 A key held through reset deassertion SHALL be treated as a new press and SHALL pulse after the normal REQ-011 latency.

Structure
REQ-019 The FSM state encodings (IDLE=2'b00, PRESS_WAIT=2'b01, PRESSED=2'b10, RELEASE_WAIT=2'b11) and the default CNT_MAX/CNT_W constants SHALL live in a shared package, key_pkg.
REQ-020 A single-channel sub-module, key_debounce_ch (synchronizer, FSM, counter, output registers), SHALL be instantiated NUM_KEYS times by a generate loop in key_debounce.

Verification (CNT_MAX=8, KEY_ACTIVE_LOW=1)
REQ-021 Clean press: key_in[0] driven 1->0 and held for 20 cycles. Required: key_pulse[0] high for exactly 1 cycle, 10 cycles after the first sampling edge; key_level[0]=1; all other bits stay 0.
REQ-022 Bounce: key_in[1] toggled with low phases of 3, 2 and 5 cycles, then held low. Required: exactly one key_pulse[1], timed from the final falling edge.
REQ-023 Release glitch: key_in[2] pressed and confirmed, then released for 4 cycles, then pressed again and held. Required: no second key_pulse[2], no key_release[2], key_level[2] stays 1.
REQ-024 Simultaneous press: key_in driven 4'b1111 -> 4'b0000 in one cycle. Required: key_pulse=4'b1111 in a single cycle; after a full release, key_release=4'b1111 in a single cycle.
REQ-025 Reset mid-operation: rst asserted at counter=5 in PRESS_WAIT, key held through deassertion. Required: outputs are 0 immediately, no pulse during reset, one key_pulse 10 cycles after deassertion.
REQ-026 Long hold: key_in[3] held low for 1000 cycles. Required: exactly one key_pulse[3] and key_level[3]=1 throughout.
